// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: serial double-dabble converter, one input bit per clk; ports clk, rst, start, bin_in -> bcd_out, busy, done (1-cycle pulse), ovf (saturated to all nines)
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);
  localparam int CW = $clog2(BIN_W + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [BIN_W:0] MAXV = (BIN_W + 1)'(10 ** DIGITS - 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0]       r_state;
  logic [BIN_W-1:0] r_bin;
  logic [BW-1:0]    r_scr;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf_pend;
  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_nxt;
  for (genvar d = 0; d < DIGITS; d++) begin : g_add3
    assign w_adj[4*d +: 4] = (r_scr[4*d +: 4] >= 4'd5) ? r_scr[4*d +: 4] + 4'd3 : r_scr[4*d +: 4];
  end
  assign w_nxt = BW'({w_adj, r_bin[BIN_W-1]});
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      bcd_out    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_bin      <= bin_in;
          r_scr      <= '0;
          r_ovf_pend <= {1'b0, bin_in} > MAXV;
          r_cnt      <= CW'(BIN_W);
          r_state    <= SHIFT;
          busy       <= 1'b1;
        end
      end else begin
        r_scr <= w_nxt;
        r_bin <= r_bin << 1;
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          bcd_out <= r_ovf_pend ? {DIGITS{4'h9}} : w_nxt;
          ovf     <= r_ovf_pend;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: randomized self-checking bench for bin_to_bcd_seq against an arithmetic decimal model
module tb_bin_to_bcd_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] bin_in = '0;
  logic [15:0] bcd_out;
  logic        busy, done, ovf;
  int checks = 0;
  int errors = 0;
  int inj_at = -1;
  logic [13:0] inj_val = '0;
  bit chain_en = 1'b0;
  logic [13:0] chain_val = '0;
  int n, bc, nd, hold_err;
  bin_to_bcd_seq dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .bcd_out(bcd_out), .busy(busy), .done(done), .ovf(ovf)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] model(input int v);
    logic [15:0] r = '0;
    if (v > 9999) return 16'h9999;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    return r;
  endfunction
  task automatic run(input logic [13:0] v, input bit pre);
    logic [15:0] hold;
    if (!pre) begin
      @(negedge clk);
      start = 1'b1;
      bin_in = v;
    end
    hold = bcd_out;
    @(posedge clk);
    #1 start = 1'b0;
    bin_in = 14'($urandom);
    n = 0; bc = 0; nd = 0; hold_err = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (chain_en) begin
          start = 1'b1;
          bin_in = chain_val;
        end
        break;
      end
      if (bcd_out !== hold) hold_err++;
      if (busy) bc++;
      n++;
      if (k == inj_at) begin
        start = 1'b1;
        bin_in = inj_val;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bcd_out !== 16'h0) begin errors++; $display("FAIL reset_bcd got %h want 0000", bcd_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
  endtask
  task automatic test_zero;
    run(14'd0, 1'b0);
    checks++; if (nd !== 1) begin errors++; $display("FAIL zero_done got %0d want 1", nd); end
    checks++; if (n !== 14) begin errors++; $display("FAIL zero_latency got %0d want 14", n); end
    checks++; if (bc !== 14) begin errors++; $display("FAIL zero_busy_cycles got %0d want 14", bc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_at_done got %b want 0", busy); end
    checks++; if (bcd_out !== 16'h0000 || ovf !== 1'b0) begin errors++; $display("FAIL zero_result got %h/%b want 0000/0", bcd_out, ovf); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width got %b want 0", done); end
  endtask
  task automatic test_values;
    int vals[8] = '{1234, 9999, 5, 10000, 16383, 42, 10, 9990};
    for (int i = 0; i < 28; i++) begin
      int v = (i < 8) ? vals[i] : int'($urandom_range(0, 16383));
      run(14'(v), 1'b0);
      checks++;
      if (nd !== 1 || n !== 14 || bcd_out !== model(v) || ovf !== (v > 9999) || hold_err != 0) begin
        errors++;
        $display("FAIL value_%0d got bcd=%h ovf=%b lat=%0d done=%0d hold_err=%0d want bcd=%h ovf=%b lat=14 done=1 hold_err=0",
                 v, bcd_out, ovf, n, nd, hold_err, model(v), v > 9999);
      end
    end
  endtask
  task automatic test_ignore_start;
    inj_at = 4;
    inj_val = 14'd777;
    run(14'd1234, 1'b0);
    inj_at = -1;
    checks++; if (nd !== 1 || n !== 14 || bcd_out !== 16'h1234) begin errors++; $display("FAIL ignore_start got bcd=%h lat=%0d done=%0d want 1234/14/1", bcd_out, n, nd); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++; if (nd !== 1 || busy !== 1'b0) begin errors++; $display("FAIL ignore_single_done got %0d pulses busy=%b want 1/0", nd, busy); end
  endtask
  task automatic test_back_to_back;
    chain_en = 1'b1;
    chain_val = 14'd4321;
    run(14'd1234, 1'b0);
    chain_en = 1'b0;
    checks++; if (bcd_out !== 16'h1234) begin errors++; $display("FAIL b2b_first got %h want 1234", bcd_out); end
    run(14'd4321, 1'b1);
    checks++; if (nd !== 1 || n !== 14 || bcd_out !== 16'h4321) begin errors++; $display("FAIL b2b_second got bcd=%h lat=%0d done=%0d want 4321/14/1", bcd_out, n, nd); end
    checks++; if (hold_err != 0) begin errors++; $display("FAIL b2b_hold got %0d changes want 0", hold_err); end
  endtask
  task automatic test_rst_abort;
    int pulses = 0;
    @(negedge clk);
    start = 1'b1;
    bin_in = 14'd9999;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || bcd_out !== 16'h0 || ovf !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_abort got busy=%b bcd=%h ovf=%b done=%b want 0/0000/0/0", busy, bcd_out, ovf, done); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_no_done got %0d want 0", pulses); end
    run(14'd8, 1'b0);
    checks++; if (nd !== 1 || bcd_out !== 16'h0008 || ovf !== 1'b0) begin errors++; $display("FAIL rst_then_8 got bcd=%h ovf=%b done=%0d want 0008/0/1", bcd_out, ovf, nd); end
  endtask
  initial begin
    test_reset;
    test_zero;
    test_values;
    test_ignore_start;
    test_back_to_back;
    test_rst_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
